// File: rtl/param_fwd_pipe.sv
// Parametrised ID/EX/WB toy pipeline with full operand forwarding, a
// two-cycle multiply that stalls issue, and a retired-write counter.
module param_fwd_pipe #(
  parameter int DATA_W  = 8,
  parameter int NREG    = 4,
  parameter int ZERO_R0 = 0,
  parameter int CNT_W   = 16,
  localparam int RA     = $clog2(NREG),
  localparam int IW     = 3 + 3 * RA
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IW-1:0]     inst,
  input  logic              inst_valid,
  output logic              inst_ready,
  input  logic [RA-1:0]     dbg_rd_addr,
  output logic [DATA_W-1:0] dbg_rd_data,
  output logic [CNT_W-1:0]  retired_cnt
);

  localparam int SHW = $clog2(DATA_W);

  typedef enum logic [2:0] {
    OP_NOP = 3'b000,
    OP_ADD = 3'b001,
    OP_SUB = 3'b010,
    OP_AND = 3'b011,
    OP_OR  = 3'b100,
    OP_XOR = 3'b101,
    OP_SHL = 3'b110,
    OP_MUL = 3'b111
  } op_e;

  op_e               id_op;
  logic [RA-1:0]     id_rs1, id_rs2, id_rd;

  logic [NREG-1:0][DATA_W-1:0] rf_q, rf_d;

  op_e               idex_op_q, idex_op_d;
  logic [DATA_W-1:0] idex_a_q, idex_a_d, idex_b_q, idex_b_d;
  logic [RA-1:0]     idex_rd_q, idex_rd_d;
  logic              idex_wen_q, idex_wen_d;

  logic [DATA_W-1:0] exwb_val_q, exwb_val_d;
  logic [RA-1:0]     exwb_rd_q, exwb_rd_d;
  logic              exwb_wen_q, exwb_wen_d;

  logic              mul_done_q, mul_done_d;
  logic [DATA_W-1:0] mul_prod_q, mul_prod_d;
  logic [CNT_W-1:0]  retired_q, retired_d;

  logic              stall, accept, ex_fwd, wb_fwd, wb_en;
  logic [DATA_W-1:0] ex_result, op_a, op_b;

  assign id_op  = op_e'(inst[IW-1 -: 3]);
  assign id_rs1 = inst[3*RA-1 -: RA];
  assign id_rs2 = inst[2*RA-1 -: RA];
  assign id_rd  = inst[RA-1:0];

  // A MUL occupies EX for two cycles; the first one blocks issue.
  assign stall      = (idex_op_q == OP_MUL) && !mul_done_q;
  assign accept     = inst_valid && !stall;
  assign inst_ready = !stall;

  assign ex_fwd = idex_wen_q && !(ZERO_R0 != 0 && idex_rd_q == '0);
  assign wb_fwd = exwb_wen_q && !(ZERO_R0 != 0 && exwb_rd_q == '0);
  assign wb_en  = wb_fwd;

  assign dbg_rd_data = rf_q[dbg_rd_addr];
  assign retired_cnt = retired_q;

  always_comb begin
    ex_result = '0;
    case (idex_op_q)
      OP_ADD:  ex_result = idex_a_q + idex_b_q;
      OP_SUB:  ex_result = idex_a_q - idex_b_q;
      OP_AND:  ex_result = idex_a_q & idex_b_q;
      OP_OR:   ex_result = idex_a_q | idex_b_q;
      OP_XOR:  ex_result = idex_a_q ^ idex_b_q;
      OP_SHL:  ex_result = idex_a_q << idex_b_q[SHW-1:0];
      OP_MUL:  ex_result = mul_prod_q;
      default: ex_result = '0;
    endcase
  end

  // Later assignments win: EX producer overrides WB, hardwired r0 overrides all.
  always_comb begin
    op_a = rf_q[id_rs1];
    if (wb_fwd && exwb_rd_q == id_rs1) op_a = exwb_val_q;
    if (ex_fwd && idex_rd_q == id_rs1) op_a = ex_result;
    if (ZERO_R0 != 0 && id_rs1 == '0) op_a = '0;
    op_b = rf_q[id_rs2];
    if (wb_fwd && exwb_rd_q == id_rs2) op_b = exwb_val_q;
    if (ex_fwd && idex_rd_q == id_rs2) op_b = ex_result;
    if (ZERO_R0 != 0 && id_rs2 == '0) op_b = '0;
  end

  always_comb begin
    idex_op_d  = idex_op_q;
    idex_a_d   = idex_a_q;
    idex_b_d   = idex_b_q;
    idex_rd_d  = idex_rd_q;
    idex_wen_d = idex_wen_q;
    if (!stall) begin
      if (accept) begin
        idex_op_d  = id_op;
        idex_a_d   = op_a;
        idex_b_d   = op_b;
        idex_rd_d  = id_rd;
        idex_wen_d = (id_op != OP_NOP);
      end else begin
        idex_op_d  = OP_NOP;
        idex_a_d   = '0;
        idex_b_d   = '0;
        idex_rd_d  = '0;
        idex_wen_d = 1'b0;
      end
    end

    exwb_wen_d = idex_wen_q && !stall;
    exwb_rd_d  = stall ? '0 : idex_rd_q;
    exwb_val_d = stall ? '0 : ex_result;

    mul_done_d = stall;
    mul_prod_d = stall ? DATA_W'(idex_a_q * idex_b_q) : mul_prod_q;

    rf_d      = rf_q;
    retired_d = retired_q;
    if (wb_en) begin
      rf_d[exwb_rd_q] = exwb_val_q;
      retired_d       = retired_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_q       <= '0;
      idex_op_q  <= OP_NOP;
      idex_a_q   <= '0;
      idex_b_q   <= '0;
      idex_rd_q  <= '0;
      idex_wen_q <= 1'b0;
      exwb_val_q <= '0;
      exwb_rd_q  <= '0;
      exwb_wen_q <= 1'b0;
      mul_done_q <= 1'b0;
      mul_prod_q <= '0;
      retired_q  <= '0;
    end else begin
      rf_q       <= rf_d;
      idex_op_q  <= idex_op_d;
      idex_a_q   <= idex_a_d;
      idex_b_q   <= idex_b_d;
      idex_rd_q  <= idex_rd_d;
      idex_wen_q <= idex_wen_d;
      exwb_val_q <= exwb_val_d;
      exwb_rd_q  <= exwb_rd_d;
      exwb_wen_q <= exwb_wen_d;
      mul_done_q <= mul_done_d;
      mul_prod_q <= mul_prod_d;
      retired_q  <= retired_d;
    end
  end

endmodule

// File: tb/tb_param_fwd_pipe.sv
// Drives two pipeline configurations side by side and checks them against an
// in-order architectural model with per-instruction write-back latency.
module tb_param_fwd_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [8:0]  inst0 = '0;
  logic        valid0 = 1'b0, ready0;
  logic [1:0]  dbga0 = '0;
  logic [7:0]  dbgd0;
  logic [15:0] cnt0;

  logic [11:0] inst1 = '0;
  logic        valid1 = 1'b0, ready1;
  logic [2:0]  dbga1 = '0;
  logic [15:0] dbgd1;
  logic [15:0] cnt1;

  logic [31:0]  s0;
  logic [127:0] s1;

  param_fwd_pipe #(.DATA_W(8), .NREG(4), .ZERO_R0(0), .CNT_W(16)) dut0 (
    .clk(clk), .rst(rst), .inst(inst0), .inst_valid(valid0), .inst_ready(ready0),
    .dbg_rd_addr(dbga0), .dbg_rd_data(dbgd0), .retired_cnt(cnt0)
  );

  param_fwd_pipe #(.DATA_W(16), .NREG(8), .ZERO_R0(1), .CNT_W(16)) dut1 (
    .clk(clk), .rst(rst), .inst(inst1), .inst_valid(valid1), .inst_ready(ready1),
    .dbg_rd_addr(dbga1), .dbg_rd_data(dbgd1), .retired_cnt(cnt1)
  );

  int vectors = 0;
  int miscompares = 0;
  int ec = 0;
  int dw [2] = '{8, 16};
  int ra [2] = '{2, 3};
  int zr [2] = '{0, 1};

  // Architectural state runs ahead; vis is what the register file should show.
  int unsigned arch [2][8];
  int unsigned vis  [2][8];
  bit          pv   [2][4];
  int          prd  [2][4];
  int unsigned pval [2][4];
  bit          exp_rdy [2] = '{1'b1, 1'b1};
  int unsigned exp_cnt [2] = '{0, 0};

  function automatic int unsigned alu(int k, int op, int unsigned a, int unsigned b);
    int unsigned m = (32'd1 << dw[k]) - 1;
    int unsigned r;
    case (op)
      1: r = a + b;
      2: r = a - b;
      3: r = a & b;
      4: r = a | b;
      5: r = a ^ b;
      6: r = a << (b & (dw[k] - 1));
      7: r = a * b;
      default: r = 0;
    endcase
    return r & m;
  endfunction

  function automatic logic [8:0] mk0(int op, int rs1, int rs2, int rd);
    return {op[2:0], rs1[1:0], rs2[1:0], rd[1:0]};
  endfunction

  function automatic logic [11:0] mk1(int op, int rs1, int rs2, int rd);
    return {op[2:0], rs1[2:0], rs2[2:0], rd[2:0]};
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, ec);
    end
  endtask

  task automatic model_edge(input int k, input bit r, input bit v, input int unsigned ins);
    int e, m, op, rs1, rs2, rd;
    int unsigned a, b, res;
    e = ec + 1;
    if (r) begin
      for (int i = 0; i < 8; i++) begin
        arch[k][i] = 0;
        vis[k][i]  = 0;
      end
      for (int i = 0; i < 4; i++) pv[k][i] = 1'b0;
      exp_rdy[k] = 1'b1;
      exp_cnt[k] = 0;
      return;
    end
    if (pv[k][e % 4]) begin
      vis[k][prd[k][e % 4]] = pval[k][e % 4];
      exp_cnt[k] = (exp_cnt[k] + 1) & 32'hFFFF;
      pv[k][e % 4] = 1'b0;
    end
    if (exp_rdy[k] && v) begin
      m   = (1 << ra[k]) - 1;
      rd  = ins & m;
      rs2 = (ins >> ra[k]) & m;
      rs1 = (ins >> (2 * ra[k])) & m;
      op  = (ins >> (3 * ra[k])) & 7;
      a   = (zr[k] != 0 && rs1 == 0) ? 0 : arch[k][rs1];
      b   = (zr[k] != 0 && rs2 == 0) ? 0 : arch[k][rs2];
      res = alu(k, op, a, b);
      if (op != 0 && !(zr[k] != 0 && rd == 0)) begin
        arch[k][rd] = res;
        pv[k][(e + ((op == 7) ? 3 : 2)) % 4]   = 1'b1;
        prd[k][(e + ((op == 7) ? 3 : 2)) % 4]  = rd;
        pval[k][(e + ((op == 7) ? 3 : 2)) % 4] = res;
      end
      exp_rdy[k] = (op != 7);
    end else begin
      exp_rdy[k] = 1'b1;
    end
  endtask

  // One clock: drive at the falling edge, compare, then advance the model.
  task automatic apply_stimulus(input bit r, input bit v0, input logic [8:0] i0,
                                input bit v1, input logic [11:0] i1,
                                input int a0, input int a1);
    @(negedge clk);
    rst    = r;
    valid0 = v0;
    inst0  = i0;
    valid1 = v1;
    inst1  = i1;
    dbga0  = (a0 < 0) ? 2'($urandom) : 2'(a0);
    dbga1  = (a1 < 0) ? 3'($urandom) : 3'(a1);
    #1;
    check_output("ready0", {31'd0, ready0}, {31'd0, exp_rdy[0]});
    check_output("dbg0", {24'd0, dbgd0}, vis[0][dbga0]);
    check_output("cnt0", {16'd0, cnt0}, exp_cnt[0]);
    check_output("ready1", {31'd0, ready1}, {31'd0, exp_rdy[1]});
    check_output("dbg1", {16'd0, dbgd1}, vis[1][dbga1]);
    check_output("cnt1", {16'd0, cnt1}, exp_cnt[1]);
    model_edge(0, r, v0, i0);
    model_edge(1, r, v1, i1);
    ec++;
  endtask

  task automatic idle(input int a0, input int a1);
    apply_stimulus(1'b0, 1'b0, '0, 1'b0, '0, a0, a1);
  endtask

  // Loads register contents directly while the pipeline is empty.
  task automatic seed_rf(input logic [31:0] v0, input logic [127:0] v1);
    @(negedge clk);
    rst = 1'b0;
    valid0 = 1'b0;
    valid1 = 1'b0;
    s0 = v0;
    s1 = v1;
    force dut0.rf_q = s0;
    force dut1.rf_q = s1;
    @(posedge clk);
    #1;
    release dut0.rf_q;
    release dut1.rf_q;
    ec++;
    for (int i = 0; i < 4; i++) begin
      arch[0][i] = s0[i*8 +: 8];
      vis[0][i]  = s0[i*8 +: 8];
    end
    for (int i = 0; i < 8; i++) begin
      arch[1][i] = s1[i*16 +: 16];
      vis[1][i]  = s1[i*16 +: 16];
    end
  endtask

  task automatic reset_pipe();
    apply_stimulus(1'b1, 1'b0, '0, 1'b0, '0, -1, -1);
    apply_stimulus(1'b1, 1'b0, '0, 1'b0, '0, -1, -1);
    idle(-1, -1);
    idle(-1, -1);
  endtask

  initial begin
    reset_pipe();
    check_output("lit_rst_ready0", {31'd0, ready0}, 32'd1);
    check_output("lit_rst_cnt0", {16'd0, cnt0}, 32'd0);
    for (int a = 0; a < 4; a++) begin
      idle(a, a + 4);
      check_output("lit_rst_rf0", {24'd0, dbgd0}, 32'd0);
      check_output("lit_rst_rf1", {16'd0, dbgd1}, 32'd0);
    end

    // EX forwarding into a dependent SUB; r0 is writable in the default config
    seed_rf({8'd0, 8'd3, 8'd5, 8'd0}, {16'd0, 16'd0, 16'd7, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0});
    apply_stimulus(1'b0, 1'b1, mk0(1, 1, 2, 3), 1'b1, mk1(1, 5, 5, 0), -1, -1);
    apply_stimulus(1'b0, 1'b1, mk0(2, 3, 2, 0), 1'b1, mk1(1, 0, 5, 4), -1, -1);
    idle(-1, -1);
    idle(-1, -1);
    idle(3, 4);
    check_output("lit_add_r3", {24'd0, dbgd0}, 32'd8);
    check_output("lit_z_r4", {16'd0, dbgd1}, 32'd7);
    idle(0, 0);
    check_output("lit_sub_r0", {24'd0, dbgd0}, 32'd5);
    check_output("lit_z_r0", {16'd0, dbgd1}, 32'd0);
    check_output("lit_z_cnt", {16'd0, cnt1}, 32'd1);

    // r1 pending in EX and WB at once
    apply_stimulus(1'b0, 1'b1, mk0(1, 1, 1, 1), 1'b0, '0, -1, -1);
    apply_stimulus(1'b0, 1'b1, mk0(1, 1, 1, 1), 1'b0, '0, -1, -1);
    idle(-1, -1);
    idle(-1, -1);
    idle(1, -1);
    check_output("lit_dbl_r1", {24'd0, dbgd0}, 32'd20);

    // MUL stall with a dependent ADD held valid
    apply_stimulus(1'b0, 1'b1, mk0(7, 1, 1, 2), 1'b0, '0, -1, -1);
    apply_stimulus(1'b0, 1'b1, mk0(1, 2, 1, 3), 1'b0, '0, -1, -1);
    check_output("lit_mul_stall", {31'd0, ready0}, 32'd0);
    apply_stimulus(1'b0, 1'b1, mk0(1, 2, 1, 3), 1'b0, '0, -1, -1);
    check_output("lit_mul_resume", {31'd0, ready0}, 32'd1);
    idle(-1, -1);
    idle(-1, -1);
    idle(2, -1);
    check_output("lit_mul_r2", {24'd0, dbgd0}, 32'd144);
    idle(3, -1);
    check_output("lit_mul_r3", {24'd0, dbgd0}, 32'd164);

    // Reset lands while a MUL is in flight
    apply_stimulus(1'b0, 1'b1, mk0(7, 1, 1, 2), 1'b0, '0, -1, -1);
    apply_stimulus(1'b1, 1'b1, mk0(1, 2, 1, 3), 1'b0, '0, -1, -1);
    idle(1, -1);
    check_output("lit_rstmul_ready", {31'd0, ready0}, 32'd1);
    check_output("lit_rstmul_cnt", {16'd0, cnt0}, 32'd0);
    check_output("lit_rstmul_r1", {24'd0, dbgd0}, 32'd0);
    idle(2, -1);
    idle(2, -1);
    idle(2, -1);
    check_output("lit_rstmul_r2", {24'd0, dbgd0}, 32'd0);

    // Randomised episodes, each starting from a fresh random register file
    for (int ep = 0; ep < 8; ep++) begin
      logic [127:0] r1v;
      reset_pipe();
      r1v = {$urandom, $urandom, $urandom, $urandom};
      r1v[15:0] = '0;
      seed_rf($urandom, r1v);
      for (int c = 0; c < 400; c++) begin
        apply_stimulus($urandom_range(0, 199) == 0,
                       $urandom_range(0, 3) != 0, 9'($urandom),
                       $urandom_range(0, 3) != 0, 12'($urandom), -1, -1);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/param_fwd_pipe.md
Name: param_fwd_pipe

Overview:
- Parametrised successor to the team's 3-stage (ID/EX/WB) toy processor with a register-file scoreboard and forwarding.
- Generalised in data width and register count; adds a valid/ready instruction handshake, a wider op set, and a 2-cycle multiply that stalls issue.
- Adds a hardwired-zero r0 mode, register-file reset, and a retired-instruction counter.
- Used as a verification and property-mining target; instructions arrive on a port, not from fetch.

Parameters:
DATA_W, 8, datapath and register width (>=4)
NREG, 4, architectural register count, power of 2, >=2; RA = log2(NREG)
ZERO_R0, 0, 1 = r0 reads 0 and writes to r0 are dropped (no forwarding of rd=0)
CNT_W, 16, width of retired counter

Ports:
clk  in  1  clock
rst  in  1  reset
inst  in  3+3*RA  {op[2:0], rs1, rs2, rd}, MSB first
inst_valid  in  1  inst present
inst_ready  out  1  ID can accept this cycle
dbg_rd_addr  in  RA  debug register index
dbg_rd_data  out  DATA_W  combinational RF read of dbg_rd_addr (no forwarding)
retired_cnt  out  CNT_W  count of register-writing instructions that completed WB

Behaviour:
- Reset: rst is synchronous and active-high; clk is the clock.
- Reset clears: all RF entries to 0, ID/EX and EX/WB valid/wen to 0, MUL state to idle, retired_cnt to 0. After reset, inst_ready=1 and dbg_rd_data=0.
- Ops:
  - 000 NOP.
  - 001 ADD, 010 SUB, 011 AND, 100 OR, 101 XOR.
  - 110 SHL: rs1 << rs2[log2(DATA_W)-1:0].
  - 111 MUL: low DATA_W bits of rs1*rs2.
  - All arithmetic is modulo 2^DATA_W. Every op except NOP writes rd.
  - A NOP or bubble produces ALU result 0, never X.
- Accept: an instruction is accepted when inst_valid && inst_ready. If not accepted, ID/EX loads a bubble (wen=0), except during a stall, when ID/EX holds.
- Latency, for an instruction accepted at edge t:
  - in EX during cycle t+1 (MUL: t+1 and t+2);
  - in WB the following cycle;
  - RF written at the end of the WB cycle, so a non-MUL result is visible on dbg_rd_data after edge t+3.
- Forwarding in ID, per operand, priority order:
  - EX-stage result when EX wen && EX rd == rs;
  - else WB value when WB wen && WB rd == rs;
  - else RF.
  - With ZERO_R0=1, rs=0 always yields 0.
  - Back-to-back dependent instructions issue with no stall.
- MUL stall:
  - First EX cycle of a MUL: inst_ready=0, ID/EX holds, EX/WB loads a bubble. The product is registered internally.
  - Second EX cycle: result available; forwarding and EX/WB load as for a normal op; inst_ready=1.
  - An instruction presented during the stall is not accepted; it is re-decoded next cycle against updated forwarding state.
  - Consecutive MULs each stall one cycle.
- WB: if wen (and not rd==0 under ZERO_R0), RF[rd] <= value and retired_cnt increments, wrapping modulo 2^CNT_W.
- Same-cycle cases: a WB write and an ID read of the same register take the forwarded WB value. An EX producer beats a WB producer for the same rd.
- Reset mid-operation: in-flight instructions (including a pending MUL) are discarded; no RF write occurs in the reset cycle.

Test Plan:
- Defaults, rst then RF seeded via ADD r1=r0+r0 etc. -> all regs 0, retired_cnt counts 1 per write; dbg read of every register returns 0.
- Seed r1=5, r2=3 via prior ops; issue ADD r3=r1+r2 then immediately SUB r0=r3-r2 -> EX forward, r3=8, r0=5 at t+3/t+4.
- ADD r1=r1+r1 three back-to-back from r1=1 -> r1=2,4,8; exercises EX-over-WB priority (r1 pending in both stages).
- MUL r2=r1*r1 (r1=20, DATA_W=8) then ADD r3=r2+r1 held valid -> inst_ready low exactly 1 cycle, r2=144, r3=164.
- ZERO_R0=1, NREG=8, DATA_W=16: ADD r0=r5+r5 (r5=7) then ADD r4=r0+r5 -> r0 stays 0, r4=7, retired_cnt +1 only.
- rst asserted the cycle after MUL issue -> no RF change, inst_ready=1 after reset, retired_cnt=0.
